// File: rtl/pll_md_pkg.sv
// rtl/pll_md_pkg.sv - MD port opcodes, controller states and counter widths
package pll_md_pkg;

    localparam logic [1:0] OPC_NOP  = 2'b00;
    localparam logic [1:0] OPC_WR   = 2'b01;
    localparam logic [1:0] OPC_RD   = 2'b10;
    localparam logic [1:0] OPC_ADDR = 2'b11;

    localparam int RD_LAT_DEF       = 2;
    localparam int RST_CYCLES_DEF   = 16;
    localparam int LOCK_TIMEOUT_DEF = 65535;

    localparam int BEAT_W = 4;
    localparam int LAT_W  = 3;
    localparam int TMR_W  = 16;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD,
        RELOCK_RST,
        RELOCK_WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/pll_md_ctrl.sv
// rtl/pll_md_ctrl.sv - PLL MD-port burst initiator; PLL_MD_RELOCK_EN adds reset/relock after writes
module pll_md_ctrl
    import pll_md_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
`ifdef PLL_MD_RELOCK_EN
    , parameter int RST_CYCLES   = RST_CYCLES_DEF
    , parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
`endif
) (
    input  logic        mdclk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        done,
    output logic        err,
    output logic [1:0]  mdopc,
    output logic        mdainc,
    output logic [7:0]  mdwdi,
    input  logic [7:0]  mdrdo,
    input  logic        pll_lock,
    output logic        pll_reset
);

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              is_wr_q, is_wr_d;
    logic [1:0]        mdopc_q, mdopc_d;
    logic              mdainc_q, mdainc_d;
    logic [7:0]        mdwdi_q, mdwdi_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              done_q, done_d;
    logic              cmd_ready_q, cmd_ready_d;
`ifdef PLL_MD_RELOCK_EN
    logic              err_q, err_d;
    logic              pll_reset_q, pll_reset_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
`endif

    // Opcode/data are computed for the cycle being entered so the MD pins line up with the state.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        is_wr_d    = is_wr_q;
        mdopc_d    = OPC_NOP;
        mdainc_d   = 1'b0;
        mdwdi_d    = mdwdi_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
`ifdef PLL_MD_RELOCK_EN
        err_d       = err_q;
        pll_reset_d = 1'b0;
        tmr_d       = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    beat_d  = cmd_len;
                    is_wr_d = cmd_write;
                    mdopc_d = OPC_ADDR;
                    mdwdi_d = cmd_addr;
                    state_d = ADDR;
`ifdef PLL_MD_RELOCK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ADDR: begin
                if (is_wr_q) begin
                    state_d = WR;
                end else begin
                    state_d  = RD_ISSUE;
                    mdopc_d  = OPC_RD;
                    mdainc_d = (beat_q != '0);
                end
            end
            WR: begin
                if (wr_valid) begin
                    mdopc_d  = OPC_WR;
                    mdwdi_d  = wr_data;
                    mdainc_d = (beat_q != '0);
                    if (beat_q == '0) begin
`ifdef PLL_MD_RELOCK_EN
                        state_d     = RELOCK_RST;
                        pll_reset_d = 1'b1;
                        tmr_d       = TMR_W'(RST_CYCLES - 1);
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        beat_d = beat_q - BEAT_W'(1);
                    end
                end
            end
            RD_ISSUE: begin
                lat_d   = LAT_W'(RD_LAT);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    rd_data_d  = mdrdo;
                    rd_valid_d = 1'b1;
                    state_d    = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (beat_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        beat_d   = beat_q - BEAT_W'(1);
                        state_d  = RD_ISSUE;
                        mdopc_d  = OPC_RD;
                        mdainc_d = (beat_q != BEAT_W'(1));
                    end
                end
            end
`ifdef PLL_MD_RELOCK_EN
            RELOCK_RST: begin
                if (tmr_q == '0) begin
                    state_d = RELOCK_WAIT;
                end else begin
                    pll_reset_d = 1'b1;
                    tmr_d       = tmr_q - TMR_W'(1);
                end
            end
            RELOCK_WAIT: begin
                if (pll_lock) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge mdclk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            lat_q       <= '0;
            is_wr_q     <= 1'b0;
            mdopc_q     <= OPC_NOP;
            mdainc_q    <= 1'b0;
            mdwdi_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef PLL_MD_RELOCK_EN
            err_q       <= 1'b0;
            pll_reset_q <= 1'b0;
            tmr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            is_wr_q     <= is_wr_d;
            mdopc_q     <= mdopc_d;
            mdainc_q    <= mdainc_d;
            mdwdi_q     <= mdwdi_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef PLL_MD_RELOCK_EN
            err_q       <= err_d;
            pll_reset_q <= pll_reset_d;
            tmr_q       <= tmr_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = (state_q == WR);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign mdopc     = mdopc_q;
    assign mdainc    = mdainc_q;
    assign mdwdi     = mdwdi_q;
`ifdef PLL_MD_RELOCK_EN
    assign err       = err_q;
    assign pll_reset = pll_reset_q;
`else
    logic unused_pll_lock;
    assign unused_pll_lock = pll_lock;
    assign err       = 1'b0;
    assign pll_reset = 1'b0;
`endif

endmodule
